sram_controller: RTL and testbench

SRAM_CONTROLLER -- requirements
Module: sram_controller

---
 rtl/sram_controller.sv | 153 +++++++++++++++
 tb/tb_sram_controller.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_controller.sv
// Mem-stage SRAM bridge: one 32-bit access = two 16-bit halves with wait states.
// Optional posted writes when SRAM_WRITE_BUFFER_EN is defined.
module sram_controller #(
    parameter int WAIT_STATES = 2,
    parameter int ADDR_BASE   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);

    localparam int CW = (WAIT_STATES < 1) ? 1 : $clog2(WAIT_STATES + 1);
    localparam logic [31:0] BASE = 32'(ADDR_BASE);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          op_wr;
    logic [16:0]   idx;
    logic [31:0]   wdata;
    logic [17:0]   addr_q;
    logic          we_n_q;
    logic          oe_n_q;
    logic          ce_n_q;
    logic          dq_oe;
    logic [15:0]   dq_out;
`ifdef SRAM_WRITE_BUFFER_EN
    logic          posted;
`endif

    logic [31:0] off;
    logic [16:0] req_idx;
    logic        last;
    logic        req;
    logic        unused_bits;

    // Offset wraps modulo 2^17 words; upper bits are simply dropped.
    assign off         = address - BASE;
    assign req_idx     = off[18:2];
    assign unused_bits = ^{off[31:19], off[1:0]};
    assign last        = (cnt == CW'(WAIT_STATES));
    assign req         = rd_en | wr_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            read_data <= '0;
            op_wr     <= 1'b0;
            idx       <= '0;
            wdata     <= '0;
            addr_q    <= '0;
            we_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            ce_n_q    <= 1'b1;
            dq_oe     <= 1'b0;
            dq_out    <= '0;
`ifdef SRAM_WRITE_BUFFER_EN
            posted    <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (req) begin
                        state  <= LOW;
                        cnt    <= '0;
                        op_wr  <= wr_en;
                        idx    <= req_idx;
                        wdata  <= write_data;
                        addr_q <= {req_idx, 1'b0};
                        ce_n_q <= 1'b0;
                        we_n_q <= ~wr_en;
                        oe_n_q <= wr_en;
                        dq_oe  <= wr_en;
                        dq_out <= write_data[15:0];
`ifdef SRAM_WRITE_BUFFER_EN
                        posted <= wr_en;
`endif
                    end
                end
                LOW: begin
                    if (last) begin
                        state  <= HIGH;
                        cnt    <= '0;
                        addr_q <= {idx, 1'b1};
                        dq_out <= wdata[31:16];
                        if (!op_wr) read_data[15:0] <= SRAM_DQ;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HIGH: begin
                    if (last) begin
                        state  <= DONE;
                        cnt    <= '0;
                        addr_q <= '0;
                        ce_n_q <= 1'b1;
                        we_n_q <= 1'b1;
                        oe_n_q <= 1'b1;
                        dq_oe  <= 1'b0;
                        if (!op_wr) read_data[31:16] <= SRAM_DQ;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
`ifdef SRAM_WRITE_BUFFER_EN
                    posted <= 1'b0;
`endif
                end
            endcase
        end
    end

    always_comb begin
        ready = 1'b0;
        unique case (state)
`ifdef SRAM_WRITE_BUFFER_EN
            // A write in IDLE is acknowledged at once and drained later.
            IDLE: ready = wr_en | ~rd_en;
            DONE: ready = posted ? ~req : 1'b1;
`else
            IDLE: ready = ~req;
            DONE: ready = 1'b1;
`endif
            LOW:  ready = 1'b0;
            HIGH: ready = 1'b0;
        endcase
    end

    assign SRAM_DQ   = dq_oe ? dq_out : 16'hzzzz;
    assign SRAM_ADDR = addr_q;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_OE_N = oe_n_q;
    assign SRAM_CE_N = ce_n_q;
    assign SRAM_UB_N = ce_n_q;
    assign SRAM_LB_N = ce_n_q;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: vector table, corner sequences, random ops
// against a word-level memory model.
module tb_sram_controller;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    wire  [15:0] SRAM_DQ;
    logic [17:0] SRAM_ADDR;
    logic        SRAM_WE_N;
    logic        SRAM_OE_N;
    logic        SRAM_CE_N;
    logic        SRAM_UB_N;
    logic        SRAM_LB_N;

    sram_controller dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .SRAM_DQ    (SRAM_DQ),
        .SRAM_ADDR  (SRAM_ADDR),
        .SRAM_WE_N  (SRAM_WE_N),
        .SRAM_OE_N  (SRAM_OE_N),
        .SRAM_CE_N  (SRAM_CE_N),
        .SRAM_UB_N  (SRAM_UB_N),
        .SRAM_LB_N  (SRAM_LB_N)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef SRAM_WRITE_BUFFER_EN
    localparam bit BUF = 1'b1;
`else
    localparam bit BUF = 1'b0;
`endif

    // Half-word SRAM device model
    logic [15:0] mem [262144];
    logic        pre_go;
    logic [17:0] pre_a;
    logic [15:0] pre_d;

    always @(posedge clk) begin
        if (pre_go) mem[pre_a] <= pre_d;
        else if (!SRAM_CE_N && !SRAM_WE_N) mem[SRAM_ADDR] <= SRAM_DQ;
    end

    assign SRAM_DQ = (!SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N) ?
                     mem[SRAM_ADDR] : 16'hzzzz;

    // Word-level reference model
    logic [31:0] ref_mem [int];
    logic [31:0] last_q;

    function automatic logic [16:0] widx(input logic [31:0] a);
        return 17'(((a - 32'd1024) / 32'd4) % 32'd131072);
    endfunction

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    logic [17:0] ad_s [10];
    logic        we_s [10];
    logic        oe_s [10];
    logic        ce_s [10];
    logic [15:0] dq_s [10];
    int          lat;
    logic [31:0] q_at;

    task automatic access(input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d);
        rd_en = rd;
        wr_en = wr;
        address = a;
        write_data = d;
        lat = -1;
        q_at = 32'hx;
        for (int k = 0; k < 10; k++) begin
            #1;
            ad_s[k] = SRAM_ADDR;
            we_s[k] = SRAM_WE_N;
            oe_s[k] = SRAM_OE_N;
            ce_s[k] = SRAM_CE_N | SRAM_UB_N | SRAM_LB_N;
            dq_s[k] = SRAM_DQ;
            if (ready && lat < 0) begin
                lat = k;
                q_at = read_data;
                rd_en = 1'b0;
                wr_en = 1'b0;
            end
            @(negedge clk);
        end
        rd_en = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic run_vec(input logic rd, input logic wr,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] eq, input logic [17:0] lo);
        int cw, co, cc;
        cw = 0;
        co = 0;
        cc = 0;
        access(rd, wr, a, d);
        chk("latency", 64'(lat), (wr && BUF) ? 64'd0 : 64'd7);
        chk("addr_lo", {ad_s[1], ad_s[3]}, {lo, lo});
        chk("addr_hi", {ad_s[4], ad_s[6]}, {lo | 18'd1, lo | 18'd1});
        chk("addr_idle", {ad_s[0], ad_s[7]}, 64'd0);
        for (int k = 0; k < 10; k++) begin
            cw += int'(!we_s[k]);
            co += int'(!oe_s[k]);
            cc += int'(!ce_s[k]);
        end
        chk("we_cnt", 64'(cw), wr ? 64'd6 : 64'd0);
        chk("oe_cnt", 64'(co), wr ? 64'd0 : 64'd6);
        chk("ce_cnt", 64'(cc), 64'd6);
        if (wr) begin
            chk("dq_lo", dq_s[2], d[15:0]);
            chk("dq_hi", dq_s[5], d[31:16]);
            chk("rdata_keep", q_at, eq);
            ref_mem[int'(widx(a))] = d;
        end else begin
            chk("rdata", q_at, eq);
            last_q = eq;
        end
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] eq;
        logic [17:0] lo;
    } vec_t;

    vec_t        vt [7];
    logic [15:0] rmask;
    logic [31:0] q;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{1'b1, 1'b0, 32'd1024, 32'h0,        32'hDEADBEEF, 18'h0};
        vt[1] = '{1'b0, 1'b1, 32'd1032, 32'h12345678, 32'hDEADBEEF, 18'h4};
        vt[2] = '{1'b1, 1'b0, 32'd1032, 32'h0,        32'h12345678, 18'h4};
        vt[3] = '{1'b1, 1'b1, 32'd1028, 32'hAABBCCDD, 32'h12345678, 18'h2};
        vt[4] = '{1'b1, 1'b0, 32'd1028, 32'h0,        32'hAABBCCDD, 18'h2};
        vt[5] = '{1'b0, 1'b1, 32'd1020, 32'hCAFEF00D, 32'hAABBCCDD, 18'h3FFFE};
        vt[6] = '{1'b1, 1'b0, 32'd1020, 32'h0,        32'hCAFEF00D, 18'h3FFFE};

        rst = 1'b1;
        rd_en = 1'b0;
        wr_en = 1'b0;
        address = '0;
        write_data = '0;
        pre_go = 1'b0;
        pre_a = '0;
        pre_d = '0;
        ref_mem[0] = 32'hDEADBEEF;
        last_q = '0;

        @(negedge clk);
        pre_go = 1'b1;
        pre_a = 18'd0;
        pre_d = 16'hBEEF;
        @(negedge clk);
        pre_a = 18'd1;
        pre_d = 16'hDEAD;
        @(negedge clk);
        pre_go = 1'b0;

        chk("rst_ready", ready, 1);
        chk("rst_strobes",
            {SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N}, 5'h1F);
        chk("rst_addr", SRAM_ADDR, 0);
        chk("rst_rdata", read_data, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++)
            run_vec(vt[i].rd, vt[i].wr, vt[i].a, vt[i].d, vt[i].eq, vt[i].lo);

        // Reset during the HIGH half of a read
        rd_en = 1'b1;
        address = 32'd1024;
        for (int k = 0; k < 4; k++) @(negedge clk);
        #1;
        chk("pre_rst_lo", read_data[15:0], 16'hBEEF);
        chk("pre_rst_addr", SRAM_ADDR, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_strobes",
            {SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N}, 5'h1F);
        chk("mid_rst_addr", SRAM_ADDR, 0);
        chk("mid_rst_rdata", read_data, 0);
        rd_en = 1'b0;
        #1;
        chk("mid_rst_ready", ready, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_vec(1'b1, 1'b0, 32'd1024, 32'h0, 32'hDEADBEEF, 18'h0);

        // Held read: back-to-back accesses
        rd_en = 1'b1;
        address = 32'd1024;
        rmask = '0;
        q = '0;
        for (int k = 0; k < 16; k++) begin
            #1;
            rmask[k] = ready;
            if (k == 15) q = read_data;
            @(negedge clk);
        end
        rd_en = 1'b0;
        chk("b2b_ready", rmask, 16'h8080);
        chk("b2b_rdata", q, 32'hDEADBEEF);
        @(negedge clk);

`ifdef SRAM_WRITE_BUFFER_EN
        // Posted write followed at once by a read of the same word
        wr_en = 1'b1;
        address = 32'd1040;
        write_data = 32'h0BADF00D;
        #1;
        chk("post_ready", ready, 1);
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b1;
        rmask = '0;
        for (int k = 1; k < 16; k++) begin
            #1;
            rmask[k] = ready;
            if (k == 15) q = read_data;
            @(negedge clk);
        end
        rd_en = 1'b0;
        chk("post_rd_ready", rmask, 16'h8000);
        chk("post_rd_data", q, 32'h0BADF00D);
        ref_mem[4] = 32'h0BADF00D;
        last_q = 32'h0BADF00D;
        @(negedge clk);
`endif

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            logic [31:0] d;
            logic [16:0] w;
            logic        rd;
            logic        wr;
            logic [31:0] eq;
            int          r;
            a = 32'd960 + 32'($urandom_range(0, 127));
            d = $urandom;
            w = widx(a);
            r = int'($urandom_range(0, 3));
            rd = (r != 1);
            wr = (r == 1) || (r == 2);
            if (!wr && !ref_mem.exists(int'(w))) begin
                rd = 1'b0;
                wr = 1'b1;
            end
            eq = wr ? last_q : ref_mem[int'(w)];
            run_vec(rd, wr, a, d, eq, {w, 1'b0});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
